// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the 2-stage fetch / decode-execute
//   pipeline. It drives the PC load enable and a bubble-select that makes the
//   fetch->decode register capture a NOP. It handles load-use interlocks,
//   kills the wrong-path instruction after a taken branch/jump, and freezes
//   the pipeline on the reserved HALT word (32'hFFFF_FFFF).
//
// Ports
//   clk          pipeline clock; registers update on the falling edge
//   rst_n        asynchronous active-low reset
//   if_instr     instruction just fetched (next to enter decode)
//   id_instr     instruction in decode/execute
//   id_valid     id_instr is a real instruction (not a bubble)
//   branch       decode: conditional branch
//   flag         ALU branch-condition flag
//   jump         decode: jump
//   pc_en        1 = PC loads its next value, 0 = PC holds
//   ifid_bubble  1 = decode register captures NOP instead of if_instr
//   halted       pipeline halted
//   state        00 RUN, 01 STALL, 10 FLUSH, 11 HALT
//   stall_cnt    saturating count of load-use bubbles
//   flush_cnt    saturating count of redirect bubbles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             branch,
    input  logic             flag,
    input  logic             jump,
    output logic             pc_en,
    output logic             ifid_bubble,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MAX_SEQ  = (LOAD_STALL > FLUSH_CYCLES) ? LOAD_STALL : FLUSH_CYCLES;
    localparam int CNT_BITS = $clog2(MAX_SEQ) + 1;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;
    localparam logic [1:0] ST_HALT  = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] STALL_LOAD = CNT_BITS'(LOAD_STALL - 1);
    localparam logic [CNT_BITS-1:0] FLUSH_LOAD = CNT_BITS'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]    EVT_ONE    = CNT_W'(1);

    logic [1:0]          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic [5:0] id_op, if_op;
    logic [4:0] id_rt, if_rs, if_rt;
    logic       if_uses_rt, load_use, redirect, halt_det;

    // Immediate/low fields of the fetched word play no part in hazard detection.
    logic       unused_if_bits;
    assign unused_if_bits = ^if_instr[15:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + EVT_ONE);
    endfunction

    assign id_op = id_instr[31:26];
    assign id_rt = id_instr[20:16];
    assign if_op = if_instr[31:26];
    assign if_rs = if_instr[25:21];
    assign if_rt = if_instr[20:16];

    // Only these opcodes actually read rt as a source; for I-type ALU ops
    // rt is the destination and cannot create a hazard.
    assign if_uses_rt = (if_op == OP_RTYPE) || (if_op == OP_SW) ||
                        (if_op == OP_BEQ)   || (if_op == OP_BNE);

    // A load into r0 never produces a value, so it never interlocks.
    assign load_use = id_valid && (id_op == OP_LW) && (id_rt != 5'd0) &&
                      ((if_rs == id_rt) || (if_uses_rt && (if_rt == id_rt)));

    assign redirect = id_valid && ((branch && flag) || jump);
    assign halt_det = id_valid && (id_instr == 32'hFFFF_FFFF);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_en       = 1'b1;
        ifid_bubble = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt_det) begin
                    pc_en       = 1'b0;
                    ifid_bubble = 1'b1;
                    state_d     = ST_HALT;
                end else if (redirect) begin
                    // PC takes the target; the wrong-path fetch is killed.
                    // A simultaneous load-use is moot since that fetch dies.
                    ifid_bubble = 1'b1;
                    flush_cnt_d = sat_inc(flush_cnt_q);
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    ifid_bubble = 1'b1;
                    stall_cnt_d = sat_inc(stall_cnt_q);
                    if (LOAD_STALL > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = STALL_LOAD;
                    end
                end
            end
            ST_STALL: begin
                pc_en       = 1'b0;
                ifid_bubble = 1'b1;
                stall_cnt_d = sat_inc(stall_cnt_q);
                cnt_d       = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = ST_RUN;
            end
            ST_FLUSH: begin
                ifid_bubble = 1'b1;
                flush_cnt_d = sat_inc(flush_cnt_q);
                cnt_d       = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = ST_RUN;
            end
            default: begin
                // HALT is sticky until reset.
                pc_en       = 1'b0;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    // Falling-edge update, aligned with the pipeline registers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = (state_q == ST_HALT);
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Three instances share the inputs:
//   A = defaults, B = LOAD_STALL 3 / FLUSH_CYCLES 2, C = CNT_W 2.
//   Each stimulus cycle pushes the hand-computed expected outputs of one
//   instance into a queue; a monitor pops and compares on the rising edge,
//   half a cycle after inputs change and away from the falling update edge.
//   Counters seen in a cycle are the values before that cycle's update.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] id_instr = '0;
    logic        id_valid = 1'b0;
    logic        branch = 1'b0;
    logic        flag = 1'b0;
    logic        jump = 1'b0;

    logic       pc_a, bub_a, hlt_a, pc_b, bub_b, hlt_b, pc_c, bub_c, hlt_c;
    logic [1:0] st_a, st_b, st_c;
    logic [7:0] sc_a, fc_a, sc_b, fc_b;
    logic [1:0] sc_c, fc_c;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .id_instr(id_instr),
        .id_valid(id_valid), .branch(branch), .flag(flag), .jump(jump),
        .pc_en(pc_a), .ifid_bubble(bub_a), .halted(hlt_a), .state(st_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    pipe_hazard_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .id_instr(id_instr),
        .id_valid(id_valid), .branch(branch), .flag(flag), .jump(jump),
        .pc_en(pc_b), .ifid_bubble(bub_b), .halted(hlt_b), .state(st_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    pipe_hazard_ctrl #(.LOAD_STALL(1), .FLUSH_CYCLES(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .id_instr(id_instr),
        .id_valid(id_valid), .branch(branch), .flag(flag), .jump(jump),
        .pc_en(pc_c), .ifid_bubble(bub_c), .halted(hlt_c), .state(st_c),
        .stall_cnt(sc_c), .flush_cnt(fc_c)
    );

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] LW5  = 32'h8C05_0000; // lw r5,0(r0)
    localparam logic [31:0] LW0  = 32'h8C00_0000; // lw r0,0(r0)
    localparam logic [31:0] ADD  = 32'h00A1_3020; // add r6,r5,r1
    localparam logic [31:0] SW5  = 32'hAC25_0000; // sw r5,0(r1)
    localparam logic [31:0] ADDI = 32'h2025_0000; // addi r5,r1,0
    localparam logic [31:0] BEQ  = 32'h1000_0004;
    localparam logic [31:0] HLT  = 32'hFFFF_FFFF;

    typedef struct {
        int          sel;
        logic [20:0] v;    // {pc_en, bubble, halted, state, stall_cnt, flush_cnt}
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        mon_e;
    logic [20:0] mon_act;

    always @(posedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.sel)
                0:       mon_act = {pc_a, bub_a, hlt_a, st_a, sc_a, fc_a};
                1:       mon_act = {pc_b, bub_b, hlt_b, st_b, sc_b, fc_b};
                default: mon_act = {pc_c, bub_c, hlt_c, st_c, 6'b0, sc_c, 6'b0, fc_c};
            endcase
            n_cmp++;
            if (mon_act !== mon_e.v) begin
                n_fail++;
                $display("FAIL %s: got pc_en=%b bub=%b halted=%b state=%b stall=%0d flush=%0d, want pc_en=%b bub=%b halted=%b state=%b stall=%0d flush=%0d",
                         mon_e.name, mon_act[20], mon_act[19], mon_act[18], mon_act[17:16],
                         mon_act[15:8], mon_act[7:0], mon_e.v[20], mon_e.v[19], mon_e.v[18],
                         mon_e.v[17:16], mon_e.v[15:8], mon_e.v[7:0]);
            end
        end
    end

    task automatic drive(input logic [31:0] idi, input logic [31:0] ifi,
                         input logic v, input logic b, input logic f, input logic j);
        id_instr = idi;
        if_instr = ifi;
        id_valid = v;
        branch   = b;
        flag     = f;
        jump     = j;
    endtask

    task automatic expect_now(input int sel, input logic pc, input logic bub,
                              input logic hl, input logic [1:0] st,
                              input logic [7:0] sc, input logic [7:0] fc,
                              input string nm);
        exp_t e;
        e.sel  = sel;
        e.v    = {pc, bub, hl, st, sc, fc};
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic cyc(input int sel, input logic [31:0] idi, input logic [31:0] ifi,
                       input logic v, input logic b, input logic f, input logic j,
                       input logic pc, input logic bub, input logic hl,
                       input logic [1:0] st, input logic [7:0] sc, input logic [7:0] fc,
                       input string nm);
        @(negedge clk);
        #1;
        drive(idi, ifi, v, b, f, j);
        expect_now(sel, pc, bub, hl, st, sc, fc, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        drive(NOP, NOP, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // ---- instance A: defaults ----
        cyc(0, NOP, NOP, 0,0,0,0, 1,0,0,2'b00, 0,0, "a_reset_idle");
        cyc(0, LW5, ADD, 1,0,0,0, 0,1,0,2'b00, 0,0, "a_lu_rs");
        cyc(0, NOP, ADD, 0,0,0,0, 1,0,0,2'b00, 1,0, "a_after_lu");
        cyc(0, LW5, SW5, 1,0,0,0, 0,1,0,2'b00, 1,0, "a_lu_sw_rt");
        cyc(0, LW5, ADDI,1,0,0,0, 1,0,0,2'b00, 2,0, "a_addi_no_lu");
        cyc(0, LW0, NOP, 1,0,0,0, 1,0,0,2'b00, 2,0, "a_lw_r0");
        cyc(0, BEQ, ADD, 1,1,1,0, 1,1,0,2'b00, 2,0, "a_taken_beq");
        cyc(0, BEQ, ADD, 1,1,0,0, 1,0,0,2'b00, 2,1, "a_not_taken");
        cyc(0, LW5, ADD, 1,0,0,1, 1,1,0,2'b00, 2,1, "a_jump_plus_lu");
        cyc(0, NOP, NOP, 0,0,0,0, 1,0,0,2'b00, 2,2, "a_tiebreak_cnts");
        cyc(0, LW5, ADD, 0,0,0,0, 1,0,0,2'b00, 2,2, "a_lu_invalid");
        cyc(0, HLT, ADD, 1,0,0,0, 0,1,0,2'b00, 2,2, "a_halt_det");
        for (int i = 0; i < 20; i++)
            cyc(0, NOP, ADD, 1,1,1,i[0], 0,1,1,2'b11, 2,2, "a_halt_hold");
        do_reset();
        cyc(0, NOP, NOP, 0,0,0,0, 1,0,0,2'b00, 0,0, "a_halt_exit");

        // ---- instance B: LOAD_STALL=3, FLUSH_CYCLES=2 ----
        do_reset();
        cyc(1, LW5, ADD, 1,0,0,0, 0,1,0,2'b00, 0,0, "b_lu_run");
        cyc(1, NOP, ADD, 0,0,0,0, 0,1,0,2'b01, 1,0, "b_stall1");
        cyc(1, NOP, ADD, 0,0,0,0, 0,1,0,2'b01, 2,0, "b_stall2");
        cyc(1, NOP, NOP, 0,0,0,0, 1,0,0,2'b00, 3,0, "b_stall_exit");
        cyc(1, BEQ, ADD, 1,1,1,0, 1,1,0,2'b00, 3,0, "b_redirect");
        cyc(1, LW5, ADD, 1,0,0,1, 1,1,0,2'b10, 3,1, "b_flush_ignores");
        cyc(1, NOP, NOP, 0,0,0,0, 1,0,0,2'b00, 3,2, "b_flush_exit");
        cyc(1, LW5, ADD, 1,0,0,0, 0,1,0,2'b00, 3,2, "b_lu_again");
        cyc(1, NOP, ADD, 0,0,0,0, 0,1,0,2'b01, 4,2, "b_stall_again");
        // async reset mid-STALL, checked before any falling edge
        @(negedge clk);
        #1;
        drive(NOP, NOP, 0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        expect_now(1, 1,0,0,2'b00, 0,0, "b_async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, NOP, NOP, 0,0,0,0, 1,0,0,2'b00, 0,0, "b_post_reset");

        // ---- instance C: CNT_W=2 saturation ----
        do_reset();
        cyc(2, LW5, ADD, 1,0,0,0, 0,1,0,2'b00, 0,0, "c_lu1");
        cyc(2, LW5, ADD, 1,0,0,0, 0,1,0,2'b00, 1,0, "c_lu2");
        cyc(2, LW5, ADD, 1,0,0,0, 0,1,0,2'b00, 2,0, "c_lu3");
        cyc(2, LW5, ADD, 1,0,0,0, 0,1,0,2'b00, 3,0, "c_lu4_sat");
        cyc(2, LW5, ADD, 1,0,0,0, 0,1,0,2'b00, 3,0, "c_lu5_sat");
        cyc(2, NOP, NOP, 0,0,0,0, 1,0,0,2'b00, 3,0, "c_sat_hold");

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 8 && sb.size() > 0; k++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
